// File: rtl/timer_cnt_cmp.sv
// timer_cnt_cmp: 64-bit free-running timer counter with a 64-bit compare
// register and a sticky compare-match interrupt status.
//
// Optional feature macro: TIMER_CNT_OVF_FLAG_EN adds a sticky overflow flag
// (ovf_st) with its clear strobe (ovf_clr).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cnt_en              one-cycle count-enable strobe
//   timer_en            timer enable level; its falling edge clears the counter
//   wdata, wstrb        register write data and byte strobes
//   cnt_lo_wr/cnt_hi_wr counter write strobes for bits [31:0] / [63:32]
//   cmp_lo_wr/cmp_hi_wr compare write strobes for bits [31:0] / [63:32]
//   int_en, int_clr     interrupt mask and write-one-to-clear for int_st
//   ovf_clr             overflow flag clear (TIMER_CNT_OVF_FLAG_EN only)
//   cnt, cmp            current counter and compare values (registered)
//   int_st              sticky compare-match status (registered)
//   ovf_st              sticky overflow status (TIMER_CNT_OVF_FLAG_EN only)
//   tim_int             interrupt request, int_st & int_en (combinational)

module timer_cnt_cmp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cnt_en,
    input  logic        timer_en,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        cnt_lo_wr,
    input  logic        cnt_hi_wr,
    input  logic        cmp_lo_wr,
    input  logic        cmp_hi_wr,
    input  logic        int_en,
    input  logic        int_clr,
`ifdef TIMER_CNT_OVF_FLAG_EN
    input  logic        ovf_clr,
    output logic        ovf_st,
`endif
    output logic [63:0] cnt,
    output logic [63:0] cmp,
    output logic        int_st,
    output logic        tim_int
);

    localparam int unsigned HALF_W = 32;
    localparam int unsigned CNT_W  = 64;
    localparam int unsigned STRB_W = 4;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cmp;
    logic             r_int_st;
    logic             r_timer_en_d;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cmp_nxt;
    logic             w_int_nxt;
    logic             w_cnt_wr;
    logic             w_fall;
    logic             w_inc;
    logic             w_match;
    logic             w_wrap;

    // Byte-strobed merge of write data into one 32-bit half.
    function automatic logic [HALF_W-1:0] f_merge(
        input logic [HALF_W-1:0] old_val,
        input logic [HALF_W-1:0] data,
        input logic [STRB_W-1:0] strb
    );
        logic [HALF_W-1:0] res;
        res = old_val;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

    // Next-state logic: write > falling-edge clear > increment > hold.
    always_comb begin
        w_cnt_wr  = cnt_lo_wr | cnt_hi_wr;
        w_fall    = r_timer_en_d & ~timer_en;
        w_inc     = cnt_en & timer_en;
        w_match   = (r_cnt == r_cmp);
        w_wrap    = 1'b0;
        w_cnt_nxt = r_cnt;
        w_cmp_nxt = r_cmp;

        if (w_cnt_wr) begin
            if (cnt_lo_wr) w_cnt_nxt[HALF_W-1:0]     = f_merge(r_cnt[HALF_W-1:0], wdata, wstrb);
            if (cnt_hi_wr) w_cnt_nxt[CNT_W-1:HALF_W] = f_merge(r_cnt[CNT_W-1:HALF_W], wdata, wstrb);
        end else if (w_fall) begin
            w_cnt_nxt = '0;
        end else if (w_inc) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            w_wrap    = &r_cnt;
        end

        if (cmp_lo_wr) w_cmp_nxt[HALF_W-1:0]     = f_merge(r_cmp[HALF_W-1:0], wdata, wstrb);
        if (cmp_hi_wr) w_cmp_nxt[CNT_W-1:HALF_W] = f_merge(r_cmp[CNT_W-1:HALF_W], wdata, wstrb);

        // Set wins over clear.
        w_int_nxt = w_match | (r_int_st & ~int_clr);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_cmp        <= '1;
            r_int_st     <= 1'b0;
            r_timer_en_d <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_cmp        <= w_cmp_nxt;
            r_int_st     <= w_int_nxt;
            r_timer_en_d <= timer_en;
        end
    end

`ifdef TIMER_CNT_OVF_FLAG_EN
    logic r_ovf_st;

    // Sticky overflow flag, set only by an increment that wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_st <= 1'b0;
        end else if (w_wrap) begin
            r_ovf_st <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf_st <= 1'b0;
        end
    end

    assign ovf_st = r_ovf_st;
`else
    // Wrap detect only feeds the optional overflow flag.
    logic w_unused;
    assign w_unused = w_wrap;
`endif

    assign cnt     = r_cnt;
    assign cmp     = r_cmp;
    assign int_st  = r_int_st;
    assign tim_int = r_int_st & int_en;

endmodule

// File: tb/tb_timer_cnt_cmp.sv
// Self-checking bench for timer_cnt_cmp: directed scenarios followed by
// randomized traffic, all checked against a behavioural model via a
// scoreboard queue drained by an independent monitor.

module tb_timer_cnt_cmp;

    logic        clk;
    logic        rst_n;
    logic        cnt_en;
    logic        timer_en;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        cnt_lo_wr;
    logic        cnt_hi_wr;
    logic        cmp_lo_wr;
    logic        cmp_hi_wr;
    logic        int_en;
    logic        int_clr;
    logic        ovf_clr;
    logic [63:0] cnt;
    logic [63:0] cmp;
    logic        int_st;
    logic        tim_int;
`ifdef TIMER_CNT_OVF_FLAG_EN
    logic        ovf_st;
`endif

    timer_cnt_cmp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_en    (cnt_en),
        .timer_en  (timer_en),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .cnt_lo_wr (cnt_lo_wr),
        .cnt_hi_wr (cnt_hi_wr),
        .cmp_lo_wr (cmp_lo_wr),
        .cmp_hi_wr (cmp_hi_wr),
        .int_en    (int_en),
        .int_clr   (int_clr),
`ifdef TIMER_CNT_OVF_FLAG_EN
        .ovf_clr   (ovf_clr),
        .ovf_st    (ovf_st),
`endif
        .cnt       (cnt),
        .cmp       (cmp),
        .int_st    (int_st),
        .tim_int   (tim_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] cnt;
        logic [63:0] cmp;
        logic        int_st;
        logic        tim_int;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [63:0] m_cnt;
    logic [63:0] m_cmp;
    logic        m_int;
    logic        m_ten_d;
    logic        m_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (d & mask) | (old_v & ~mask);
    endfunction

    task automatic model_reset();
        m_cnt   = 64'h0;
        m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
        m_int   = 1'b0;
        m_ten_d = 1'b0;
        m_ov_clear();
    endtask

    task automatic m_ov_clear();
        m_ovf = 1'b0;
    endtask

    task automatic clear_strobes();
        cnt_lo_wr = 1'b0;
        cnt_hi_wr = 1'b0;
        cmp_lo_wr = 1'b0;
        cmp_hi_wr = 1'b0;
        int_clr   = 1'b0;
        ovf_clr   = 1'b0;
    endtask

    // Called just after a falling edge with inputs set: predicts the state
    // after the next rising edge, queues it, and returns at the next falling edge.
    task automatic tick();
        logic [63:0] ncnt;
        logic [63:0] ncmp;
        logic        nint;
        logic        novf;
        logic        wrap;
        exp_t        e;
        ncnt = m_cnt;
        ncmp = m_cmp;
        wrap = 1'b0;
        if (cnt_lo_wr || cnt_hi_wr) begin
            if (cnt_lo_wr) ncnt[31:0]  = merge(m_cnt[31:0], wdata, wstrb);
            if (cnt_hi_wr) ncnt[63:32] = merge(m_cnt[63:32], wdata, wstrb);
        end else if (m_ten_d && !timer_en) begin
            ncnt = 64'h0;
        end else if (cnt_en && timer_en) begin
            ncnt = m_cnt + 64'd1;
            wrap = (ncnt == 64'h0);
        end
        if (cmp_lo_wr) ncmp[31:0]  = merge(m_cmp[31:0], wdata, wstrb);
        if (cmp_hi_wr) ncmp[63:32] = merge(m_cmp[63:32], wdata, wstrb);
        if (m_cnt == m_cmp) nint = 1'b1;
        else if (int_clr)   nint = 1'b0;
        else                nint = m_int;
        if (wrap)         novf = 1'b1;
        else if (ovf_clr) novf = 1'b0;
        else              novf = m_ovf;
        m_cnt   = ncnt;
        m_cmp   = ncmp;
        m_int   = nint;
        m_ovf   = novf;
        m_ten_d = timer_en;
        e.cnt     = ncnt;
        e.cmp     = ncmp;
        e.int_st  = nint;
        e.tim_int = nint & int_en;
        e.ovf     = novf;
        q.push_back(e);
        @(negedge clk);
        clear_strobes();
    endtask

    // Monitor: every rising edge out of reset the DUT presents a new state.
    always @(posedge clk) begin
        #1;
        if (rst_n && q.size() > 0) begin
            mon_e = q.pop_front();
            chk("sb_cnt", cnt, mon_e.cnt);
            chk("sb_cmp", cmp, mon_e.cmp);
            chk("sb_int_st", 64'(int_st), 64'(mon_e.int_st));
            chk("sb_tim_int", 64'(tim_int), 64'(mon_e.tim_int));
`ifdef TIMER_CNT_OVF_FLAG_EN
            chk("sb_ovf_st", 64'(ovf_st), 64'(mon_e.ovf));
`endif
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_cnt"}, cnt, 64'h0);
        chk({tag, "_cmp"}, cmp, 64'hFFFF_FFFF_FFFF_FFFF);
        chk({tag, "_int_st"}, 64'(int_st), 64'h0);
        chk({tag, "_tim_int"}, 64'(tim_int), 64'h0);
`ifdef TIMER_CNT_OVF_FLAG_EN
        chk({tag, "_ovf_st"}, 64'(ovf_st), 64'h0);
`endif
    endtask

    initial begin
        int guard;
        rst_n    = 1'b1;
        cnt_en   = 1'b0;
        timer_en = 1'b0;
        wdata    = '0;
        wstrb    = '0;
        int_en   = 1'b0;
        clear_strobes();
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Five count pulses.
        timer_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cnt_en = 1'b1; tick();
            cnt_en = 1'b0; tick();
        end
        chk("five_pulses_cnt", cnt, 64'd5);
        chk("five_pulses_int", 64'(int_st), 64'h0);

        // Compare at 0x10, continuous counting.
        wdata = 32'h0;  wstrb = 4'hF; cmp_hi_wr = 1'b1; tick();
        wdata = 32'h10; wstrb = 4'hF; cmp_lo_wr = 1'b1; tick();
        int_en = 1'b1;
        cnt_en = 1'b1;
        guard  = 0;
        while (m_cnt != 64'h11 && guard < 100) begin
            tick();
            guard++;
        end
        cnt_en = 1'b0;
        chk("cmp_hit_cnt", cnt, 64'h11);
        chk("cmp_hit_int", 64'(int_st), 64'h1);
        chk("cmp_hit_tim_int", 64'(tim_int), 64'h1);
        int_clr = 1'b1; tick();
        chk("int_clr", 64'(int_st), 64'h0);

        // Wrap through all-ones.
        wdata = 32'hFFFF_FFFF; wstrb = 4'hF; cnt_hi_wr = 1'b1; tick();
        wdata = 32'hFFFF_FFFE; wstrb = 4'hF; cnt_lo_wr = 1'b1; tick();
        cnt_en = 1'b1; tick(); tick();
        cnt_en = 1'b0;
        chk("wrap_cnt", cnt, 64'h0);
`ifdef TIMER_CNT_OVF_FLAG_EN
        chk("wrap_ovf", 64'(ovf_st), 64'h1);
`endif

        // Byte-strobed write beats a simultaneous increment.
        cnt_en = 1'b1; wdata = 32'hAABB_CCDD; wstrb = 4'b0101; cnt_lo_wr = 1'b1; tick();
        cnt_en = 1'b0;
        chk("strb_write_cnt", cnt, 64'h00BB_00DD);

        // Falling-edge clear, then counting ignored while disabled.
        wdata = 32'h1234; wstrb = 4'hF; cnt_lo_wr = 1'b1; tick();
        chk("load_1234", cnt, 64'h1234);
        timer_en = 1'b0; tick();
        chk("fall_clear", cnt, 64'h0);
        cnt_en = 1'b1; tick(); tick(); tick();
        cnt_en = 1'b0;
        chk("disabled_hold", cnt, 64'h0);

        // Match and clear in the same cycle: set wins.
        wdata = 32'h0; wstrb = 4'hF; cmp_lo_wr = 1'b1; tick();
        tick();
        int_clr = 1'b1; tick();
        chk("set_over_clr", 64'(int_st), 64'h1);

        // Asynchronous reset mid-count.
        wdata = 32'h100; wstrb = 4'hF; cmp_lo_wr = 1'b1; tick();
        timer_en = 1'b1; cnt_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        #3 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        cnt_en = 1'b0; timer_en = 1'b0; int_en = 1'b0;
        clear_strobes();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) timer_en = ~timer_en;
            if ($urandom_range(0, 9) == 0)  int_en   = ~int_en;
            cnt_en  = ($urandom_range(0, 9) < 7);
            int_clr = ($urandom_range(0, 9) == 0);
            ovf_clr = ($urandom_range(0, 9) == 0);
            wstrb   = 4'($urandom());
            wdata   = $urandom();
            case ($urandom_range(0, 39))
                0: cnt_lo_wr = 1'b1;
                1: cnt_hi_wr = 1'b1;
                2: begin cnt_lo_wr = 1'b1; cnt_hi_wr = 1'b1; end
                3: cmp_lo_wr = 1'b1;
                4: cmp_hi_wr = 1'b1;
                5: begin
                    cmp_lo_wr = 1'b1; wstrb = 4'hF;
                    wdata = m_cnt[31:0] + 32'($urandom_range(0, 6));
                end
                6: begin cmp_hi_wr = 1'b1; wstrb = 4'hF; wdata = m_cnt[63:32]; end
                7: begin cnt_hi_wr = 1'b1; wstrb = 4'hF; wdata = 32'hFFFF_FFFF; end
                8: begin cnt_lo_wr = 1'b1; wstrb = 4'hF; wdata = 32'hFFFF_FFF8; end
                default: ;
            endcase
            tick();
        end

        chk("queue_drained", 64'(q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_cnt_cmp.md
TIMER_CNT_CMP -- requirements
Module: timer_cnt_cmp

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 cnt_en  input  1  one-cycle count-enable strobe from the counter-control stage; already gated by halt/debug and divider.
REQ-004 timer_en  input  1  timer enable level from the control register.
REQ-005 wdata  input  32  register write data.
REQ-006 wstrb  input  4  byte strobes for wdata; bit n covers wdata[8n+7:8n].
REQ-007 cnt_lo_wr, cnt_hi_wr  input  1 each  write strobes for counter bits [31:0] and [63:32].
REQ-008 cmp_lo_wr, cmp_hi_wr  input  1 each  write strobes for compare bits [31:0] and [63:32].
REQ-009 int_en  input  1  interrupt mask; 1 = interrupt enabled.
REQ-010 int_clr  input  1  write-one-to-clear strobe for int_st.
REQ-011 cnt  output  64  current counter value.
REQ-012 cmp  output  64  current compare value.
REQ-013 int_st  output  1  sticky compare-match status.
REQ-014 tim_int  output  1  interrupt request, equal to int_st & int_en, combinational.

Function
REQ-015 Counter priority per cycle: software write > timer_en falling-edge clear > increment > hold.
REQ-016 Software write: for each half, bytes with wstrb=1 take wdata; bytes with wstrb=0 keep their value. The whole 64-bit counter does not increment that cycle.
REQ-017 Falling-edge clear: timer_en is registered (timer_en_d). When timer_en_d=1 and timer_en=0, the counter loads 64'h0 on that edge.
REQ-018 Increment: when cnt_en=1 and timer_en=1, cnt <= cnt + 1 modulo 2^64. 64'hFFFF_FFFF_FFFF_FFFF wraps to 64'h0 with no stall.
REQ-019 cnt_en is ignored while timer_en=0; the counter holds its value.
REQ-020 Compare writes are byte-strobed per REQ-016 and take effect on the next edge. They are independent of the counter writes.
REQ-021 Match: match = (cnt == cmp), evaluated on the registered values every cycle, regardless of timer_en.
REQ-022 int_st is set to 1 on the edge after match=1 and stays at 1 until cleared.
REQ-023 int_clr=1 clears int_st on the next edge, unless match=1 in the same cycle; set has priority over clear.
REQ-024 Writing cnt or cmp so that they become equal sets int_st one cycle later (no special suppression).
REQ-025 cnt and cmp are visible on outputs the same cycle they are registered. There is no extra pipeline stage.
REQ-026 Latency: cnt_en at edge N -> cnt updated at edge N -> int_st set at edge N+1 if the new cnt equals cmp.

Reset
REQ-027 While rst_n=0: cnt=64'h0, cmp=64'hFFFF_FFFF_FFFF_FFFF, int_st=0, timer_en_d=0, and therefore tim_int=0.
REQ-028 Reset asserted mid-count forces the values in REQ-027 immediately, independent of clk. Deassertion takes effect at the first edge after rst_n=1.

Configuration
REQ-029 Macro TIMER_CNT_OVF_FLAG_EN defined adds output ovf_st (1 bit) and input ovf_clr (1 bit).
REQ-030 With the macro, ovf_st is set on the edge where an increment wraps 64'hFFFF_FFFF_FFFF_FFFF to 64'h0.
REQ-031 With the macro, ovf_st is cleared by ovf_clr; set has priority over clear, and the reset value is 0.
REQ-032 With the macro, a software write or a falling-edge clear never sets ovf_st.
REQ-033 Without the macro, the ovf_st and ovf_clr ports and their logic are absent; all other behaviour is identical.

Verification
REQ-034 Reset then timer_en=1 with cnt_en pulsed 5 times -> cnt=5; int_st=0; tim_int=0.
REQ-035 cmp written to 64'h10, int_en=1, continuous cnt_en -> int_st=1 and tim_int=1 exactly one cycle after cnt=0x10; int_clr while cnt=0x11 -> int_st=0.
REQ-036 cnt_hi_wr with wdata=0xFFFF_FFFF, wstrb=4'hF, then cnt_lo_wr with wdata=0xFFFF_FFFE, then 2 cnt_en pulses -> cnt=0. With TIMER_CNT_OVF_FLAG_EN, ovf_st=1 after the wrap.
REQ-037 cnt_lo_wr, wdata=0xAABB_CCDD, wstrb=4'b0101, with cnt_en=1 in the same cycle from cnt=0 -> cnt[31:0]=0x00BB_00DD with no increment.
REQ-038 cnt=0x1234 then timer_en 1->0 -> cnt=0 the next edge. cnt_en pulses while timer_en=0 -> cnt stays 0.
REQ-039 match and int_clr asserted in the same cycle -> int_st remains 1. rst_n pulsed low mid-count -> all outputs take their REQ-027 values immediately.
